blink_bank: RTL and testbench



---
 rtl/blink_pkg.sv | 23 ++
 rtl/blink_chan.sv | 96 +++++++++
 rtl/blink_bank.sv | 74 +++++++
 tb/tb_blink_bank.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared types and defaults for the LED blink bank
// Purpose: mode encoding, default parameter values and the channel-select width helper.
// Ports: none (package).
package blink_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    BURST = 2'd3
  } blink_mode_e;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_CBITS    = 21;
  localparam int DEF_DBITS    = 8;
  localparam int DEF_BBITS    = 8;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blink_chan.sv
// rtl/blink_chan.sv - one LED channel: mode, half-period divider and burst counter
// Purpose: runs OFF/ON/BLINK/BURST on the shared tick and pulses done when a burst ends.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   tick_i            shared prescaler tick
//   we_i              config write for this channel
//   mode_i, div_i,    config fields loaded on we_i
//   burst_i
//   led_o             registered LED level
//   done_o            one-cycle pulse when a burst completes
module blink_chan
  import blink_pkg::*;
#(
  parameter int DBITS = DEF_DBITS,
  parameter int BBITS = DEF_BBITS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              we_i,
  input  blink_mode_e       mode_i,
  input  logic [DBITS-1:0]  div_i,
  input  logic [BBITS-1:0]  burst_i,
  output logic              led_o,
  output logic              done_o
);

  blink_mode_e      mode_q, mode_d;
  logic [DBITS-1:0] div_q, div_d;
  logic [DBITS-1:0] dcnt_q, dcnt_d;
  logic [BBITS-1:0] bcnt_q, bcnt_d;
  logic             led_q, led_d;
  logic             done_q, done_d;

  always_comb begin
    mode_d = mode_q;
    div_d  = div_q;
    dcnt_d = dcnt_q;
    bcnt_d = bcnt_q;
    led_d  = led_q;
    done_d = 1'b0;
    // A write takes priority over a coincident tick; the tick is lost for this channel.
    if (we_i) begin
      mode_d = mode_i;
      div_d  = div_i;
      dcnt_d = div_i;
      bcnt_d = burst_i;
      led_d  = (mode_i != OFF);
      // An empty burst completes immediately.
      if (mode_i == BURST && burst_i == '0) begin
        mode_d = OFF;
        led_d  = 1'b0;
        done_d = 1'b1;
      end
    end else if (tick_i && (mode_q == BLINK || mode_q == BURST)) begin
      if (dcnt_q != '0) begin
        dcnt_d = dcnt_q - DBITS'(1);
      end else begin
        dcnt_d = div_q;
        led_d  = ~led_q;
        // Bursts count on the falling toggle only.
        if (mode_q == BURST && led_q) begin
          if (bcnt_q == BBITS'(1)) begin
            mode_d = OFF;
            led_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            bcnt_d = bcnt_q - BBITS'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= OFF;
      div_q  <= '0;
      dcnt_q <= '0;
      bcnt_q <= '0;
      led_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      div_q  <= div_d;
      dcnt_q <= dcnt_d;
      bcnt_q <= bcnt_d;
      led_q  <= led_d;
      done_q <= done_d;
    end
  end

  assign led_o  = led_q;
  assign done_o = done_q;

endmodule

// File: rtl/blink_bank.sv
// rtl/blink_bank.sv - shared prescaler plus CHANNELS independent LED blink channels
// Purpose: free-running prescaler generates the tick; each channel blinks per its config.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cfg_we_i, cfg_ch_i     config write strobe and target channel
//   cfg_mode_i, cfg_div_i, config fields
//   cfg_burst_i
//   led_o                  registered LED levels
//   flg_o                  one-cycle pulse one clock after each prescaler wrap
//   done_o                 per-channel burst-complete pulses
module blink_bank
  import blink_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CBITS    = DEF_CBITS,
  parameter int DBITS    = DEF_DBITS,
  parameter int BBITS    = DEF_BBITS
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cfg_we_i,
  input  logic [ch_bits(CHANNELS)-1:0]  cfg_ch_i,
  input  blink_mode_e                   cfg_mode_i,
  input  logic [DBITS-1:0]              cfg_div_i,
  input  logic [BBITS-1:0]              cfg_burst_i,
  output logic [CHANNELS-1:0]           led_o,
  output logic                          flg_o,
  output logic [CHANNELS-1:0]           done_o
);

  localparam int CHW = ch_bits(CHANNELS);

  logic [CBITS-1:0] pcnt_q, pcnt_d;
  logic             flg_q, flg_d;
  logic             tick;

  assign tick   = &pcnt_q;
  assign pcnt_d = pcnt_q + CBITS'(1);
  assign flg_d  = tick;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
      flg_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      flg_q  <= flg_d;
    end
  end

  assign flg_o = flg_q;

  // Select codes at or above CHANNELS match no instance, so such writes vanish.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic we;
    assign we = cfg_we_i && (cfg_ch_i == CHW'(i));

    blink_chan #(
      .DBITS (DBITS),
      .BBITS (BBITS)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .tick_i  (tick),
      .we_i    (we),
      .mode_i  (cfg_mode_i),
      .div_i   (cfg_div_i),
      .burst_i (cfg_burst_i),
      .led_o   (led_o[i]),
      .done_o  (done_o[i])
    );
  end

endmodule

// File: tb/tb_blink_bank.sv
// tb/tb_blink_bank.sv - scoreboard bench for blink_bank (4-channel and 3-channel builds)
module tb_blink_bank;
  import blink_pkg::*;

  localparam int TPER = 8;

  typedef struct packed {
    logic [3:0] led;
    logic [3:0] done;
    logic       flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  blink_mode_e cfg_mode = OFF;
  logic [3:0]  cfg_div = '0;
  logic [3:0]  cfg_burst = '0;
  logic [3:0]  led4, done4;
  logic [2:0]  led3, done3;
  logic        flg4, flg3;

  always #5 clk = ~clk;

  blink_bank #(.CHANNELS(4), .CBITS(3), .DBITS(4), .BBITS(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_mode_i(cfg_mode), .cfg_div_i(cfg_div), .cfg_burst_i(cfg_burst),
    .led_o(led4), .flg_o(flg4), .done_o(done4)
  );

  // Same stimulus; select code 3 is out of range here.
  blink_bank #(.CHANNELS(3), .CBITS(3), .DBITS(4), .BBITS(4)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_mode_i(cfg_mode), .cfg_div_i(cfg_div), .cfg_burst_i(cfg_burst),
    .led_o(led3), .flg_o(flg3), .done_o(done3)
  );

  int          errors = 0;
  int          checks = 0;
  int          edges = 0;
  string       tname = "none";
  exp_t        sb[$];
  blink_mode_e pm[4];
  int          pw[4], pd[4], pn[4];

  function automatic int ticks(input int w, input int e);
    return (e / TPER) - (w / TPER);
  endfunction

  // Returns {done, led} for channel c after clock edge e from its last programmed config.
  function automatic logic [1:0] chan_exp(input int c, input int e);
    logic led, done;
    int k, kp, lim;
    led = 1'b0;
    done = 1'b0;
    case (pm[c])
      ON:    led = 1'b1;
      BLINK: begin
        k = ticks(pw[c], e) / (pd[c] + 1);
        led = (k % 2 == 0);
      end
      BURST: begin
        if (pn[c] == 0) begin
          done = (e == pw[c]);
        end else begin
          lim = 2 * pn[c] - 1;
          k = ticks(pw[c], e) / (pd[c] + 1);
          if (k >= lim) begin
            kp = ticks(pw[c], e - 1) / (pd[c] + 1);
            done = (e > pw[c]) && (kp < lim);
          end else begin
            led = (k % 2 == 0);
          end
        end
      end
      default: ;
    endcase
    return {done, led};
  endfunction

  function automatic exp_t exp_at(input int e);
    exp_t x;
    logic [1:0] r;
    x = '0;
    for (int c = 0; c < 4; c++) begin
      r = chan_exp(c, e);
      x.led[c]  = r[0];
      x.done[c] = r[1];
    end
    x.flg = (e > 0) && (e % TPER == 0);
    return x;
  endfunction

  // Scoreboard: push expectations for the next n edges, then pop and compare each edge.
  task automatic run(input int n);
    exp_t x;
    for (int i = 1; i <= n; i++) sb.push_back(exp_at(edges + i));
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edges++;
      #1;
      x = sb.pop_front();
      checks++;
      if (led4 !== x.led) begin
        errors++;
        $display("FAIL %s led4 edge %0d: got %b want %b", tname, edges, led4, x.led);
      end
      checks++;
      if (done4 !== x.done) begin
        errors++;
        $display("FAIL %s done4 edge %0d: got %b want %b", tname, edges, done4, x.done);
      end
      checks++;
      if (flg4 !== x.flg) begin
        errors++;
        $display("FAIL %s flg4 edge %0d: got %b want %b", tname, edges, flg4, x.flg);
      end
      checks++;
      if (led3 !== x.led[2:0]) begin
        errors++;
        $display("FAIL %s led3 edge %0d: got %b want %b", tname, edges, led3, x.led[2:0]);
      end
      checks++;
      if (done3 !== x.done[2:0]) begin
        errors++;
        $display("FAIL %s done3 edge %0d: got %b want %b", tname, edges, done3, x.done[2:0]);
      end
      checks++;
      if (flg3 !== x.flg) begin
        errors++;
        $display("FAIL %s flg3 edge %0d: got %b want %b", tname, edges, flg3, x.flg);
      end
    end
  endtask

  task automatic write_cfg(input int ch, input blink_mode_e m, input int d, input int n);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mode  = m;
    cfg_div   = 4'(d);
    cfg_burst = 4'(n);
    pm[ch] = m;
    pw[ch] = edges + 1;
    pd[ch] = d;
    pn[ch] = n;
    run(1);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    cfg_we = 1'b0;
    for (int c = 0; c < 4; c++) begin
      pm[c] = OFF;
      pw[c] = 0;
      pd[c] = 0;
      pn[c] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
  endtask

  task automatic test_reset();
    tname = "reset";
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({led4, done4, flg4} !== 9'd0) begin
      errors++;
      $display("FAIL reset_dut4: got %b want 0", {led4, done4, flg4});
    end
    checks++;
    if ({led3, done3, flg3} !== 7'd0) begin
      errors++;
      $display("FAIL reset_dut3: got %b want 0", {led3, done3, flg3});
    end
    do_reset();
    run(26);
  endtask

  task automatic test_blink();
    tname = "blink";
    do_reset();
    run(2);
    write_cfg(0, BLINK, 1, 0);
    run(60);
  endtask

  task automatic test_burst();
    tname = "burst";
    do_reset();
    run(1);
    write_cfg(2, BURST, 0, 3);
    run(50);
  endtask

  task automatic test_conflict();
    tname = "conflict";
    do_reset();
    run(2);
    write_cfg(1, BLINK, 0, 0);
    write_cfg(3, BLINK, 0, 0);
    run(19);
    // Lands on the edge that samples tick 24, where ch1 would otherwise fall.
    write_cfg(1, ON, 0, 0);
    run(20);
  endtask

  task automatic test_abort_invalid();
    tname = "abort_invalid";
    do_reset();
    run(1);
    write_cfg(2, BURST, 1, 4);
    run(20);
    write_cfg(2, OFF, 0, 0);
    run(30);
    write_cfg(0, BLINK, 0, 0);
    run(5);
    write_cfg(3, ON, 0, 0);
    run(20);
  endtask

  task automatic test_async_reset_zero_burst();
    tname = "async_reset";
    do_reset();
    run(1);
    write_cfg(2, BURST, 0, 3);
    run(15);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({led4, done4, flg4} !== 9'd0) begin
      errors++;
      $display("FAIL async_reset_dut4: got %b want 0", {led4, done4, flg4});
    end
    checks++;
    if ({led3, done3, flg3} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset_dut3: got %b want 0", {led3, done3, flg3});
    end
    tname = "zero_burst";
    do_reset();
    run(3);
    write_cfg(1, BURST, 2, 0);
    run(20);
  endtask

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_conflict();
    test_abort_invalid();
    test_async_reset_zero_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
